// File: rtl/opcode_alu_func_issue_if.sv
// Issue-stage bundle between the opcode source, the ALU-function register and the ALU.
// The master side drives opcodes and ALU back-pressure; the slave side is the issue block.
interface opcode_alu_func_issue_if;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] opFunc;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] func;
    logic       illegal;
    logic       hilo_busy;

    modport master (
        output in_valid, opFunc, flush, out_ready,
        input  in_ready, out_valid, func, illegal, hilo_busy
    );

    modport slave (
        input  in_valid, opFunc, flush, out_ready,
        output in_ready, out_valid, func, illegal, hilo_busy
    );
endinterface

// File: rtl/opcode_alu_func_issue.sv
// Maps a decoded opcode class onto a registered ALU function (one-entry output register)
// and stalls HI/LO consumers while a multi-cycle multiply/divide still owns HI/LO.
module opcode_alu_func_issue #(
    parameter int unsigned MULT_CYCLES = 4,
    parameter int unsigned DIV_CYCLES  = 32,
    parameter bit          HAS_MULDIV  = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    opcode_alu_func_issue_if.slave bus
);

    typedef enum logic [5:0] {
        OP_ADD = 6'd0, OP_ADDI, OP_ADDIU, OP_ADDU,
        OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW,
        OP_SUB, OP_SUBU, OP_BEQ, OP_BNE,
        OP_AND, OP_ANDI, OP_OR, OP_ORI, OP_XOR, OP_XORI, OP_NOR,
        OP_SLT, OP_SLTI, OP_SLTIU, OP_SLTU,
        OP_LUI, OP_SLL, OP_SLLV, OP_SRL, OP_SRLV, OP_SRA, OP_SRAV,
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
        OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO,
        OP_BGEZ, OP_BGTZ, OP_BLEZ, OP_BLTZ, OP_BGEZAL, OP_BLTZAL,
        OP_J, OP_JAL, OP_JR, OP_JALR,
        OP_BREAK, OP_SYSCALL, OP_MFC0, OP_MTC0, OP_NOP
    } opcode_e;

    typedef enum logic [4:0] {
        ALU_NONE = 5'd0, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLTS, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA,
        ALU_MULS, ALU_MULU, ALU_DIVS, ALU_DIVU,
        ALU_MFHI, ALU_MFLO, ALU_MTHI, ALU_MTLO
    } alu_func_e;

    localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES);
    localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES);

    alu_func_e  dec_func;
    logic       dec_illegal;
    logic       dec_mul;
    logic       dec_div;
    logic       dec_hilo;

    logic       out_valid_q, out_valid_d;
    alu_func_e  func_q, func_d;
    logic       illegal_q, illegal_d;
    logic [5:0] busy_cnt_q, busy_cnt_d;
    logic       hilo_busy_q, hilo_busy_d;

    logic       hazard;
    logic       in_ready;
    logic       accept;

    always_comb begin
        // NOTE: every output gets a default before the case, so no path can infer a latch.
        dec_func    = ALU_NONE;
        dec_illegal = 1'b0;
        dec_mul     = 1'b0;
        dec_div     = 1'b0;
        dec_hilo    = 1'b0;
        case (bus.opFunc)
            OP_ADD, OP_ADDI, OP_ADDIU, OP_ADDU,
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW,
            OP_SB, OP_SH, OP_SW:                     dec_func = ALU_ADD;
            OP_SUB, OP_SUBU, OP_BEQ, OP_BNE:         dec_func = ALU_SUB;
            OP_AND, OP_ANDI:                         dec_func = ALU_AND;
            OP_OR, OP_ORI:                           dec_func = ALU_OR;
            OP_XOR, OP_XORI:                         dec_func = ALU_XOR;
            OP_NOR:                                  dec_func = ALU_NOR;
            OP_SLT, OP_SLTI:                         dec_func = ALU_SLTS;
            OP_SLTU, OP_SLTIU:                       dec_func = ALU_SLTU;
            OP_LUI, OP_SLL, OP_SLLV:                 dec_func = ALU_SLL;
            OP_SRL, OP_SRLV:                         dec_func = ALU_SRL;
            OP_SRA, OP_SRAV:                         dec_func = ALU_SRA;
            OP_MULT:  begin dec_func = ALU_MULS; dec_mul = 1'b1; dec_hilo = 1'b1; end
            OP_MULTU: begin dec_func = ALU_MULU; dec_mul = 1'b1; dec_hilo = 1'b1; end
            OP_DIV:   begin dec_func = ALU_DIVS; dec_div = 1'b1; dec_hilo = 1'b1; end
            OP_DIVU:  begin dec_func = ALU_DIVU; dec_div = 1'b1; dec_hilo = 1'b1; end
            OP_MFHI:  begin dec_func = ALU_MFHI; dec_hilo = 1'b1; end
            OP_MFLO:  begin dec_func = ALU_MFLO; dec_hilo = 1'b1; end
            OP_MTHI:  begin dec_func = ALU_MTHI; dec_hilo = 1'b1; end
            OP_MTLO:  begin dec_func = ALU_MTLO; dec_hilo = 1'b1; end
            OP_BGEZ, OP_BGTZ, OP_BLEZ, OP_BLTZ, OP_BGEZAL, OP_BLTZAL,
            OP_J, OP_JAL, OP_JR, OP_JALR,
            OP_BREAK, OP_SYSCALL, OP_MFC0, OP_MTC0, OP_NOP: dec_func = ALU_NONE;
            default:                                 dec_illegal = 1'b1;
        endcase

        // Without a mul/div unit every HI/LO op is simply an unsupported class.
        if (!HAS_MULDIV && dec_hilo) begin
            dec_func    = ALU_NONE;
            dec_illegal = 1'b1;
            dec_mul     = 1'b0;
            dec_div     = 1'b0;
            dec_hilo    = 1'b0;
        end
    end

    assign hazard   = hilo_busy_q && dec_hilo;
    assign in_ready = (!out_valid_q || bus.out_ready) && !hazard && !bus.flush;
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        func_d      = func_q;
        illegal_d   = illegal_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            func_d      = dec_func;
            illegal_d   = dec_illegal;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Flush only empties the output register; an issued mul/div keeps counting.
    always_comb begin
        busy_cnt_d = busy_cnt_q;
        if (!HAS_MULDIV) begin
            busy_cnt_d = '0;
        end else if (accept && dec_mul) begin
            busy_cnt_d = MULT_LOAD;
        end else if (accept && dec_div) begin
            busy_cnt_d = DIV_LOAD;
        end else if (busy_cnt_q != '0) begin
            busy_cnt_d = busy_cnt_q - 6'd1;
        end
        hilo_busy_d = (busy_cnt_d != '0);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            func_q      <= ALU_NONE;
            illegal_q   <= 1'b0;
            busy_cnt_q  <= '0;
            hilo_busy_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            out_valid_q <= out_valid_d;
            func_q      <= func_d;
            illegal_q   <= illegal_d;
            busy_cnt_q  <= busy_cnt_d;
            hilo_busy_q <= hilo_busy_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.func      = func_q;
    assign bus.illegal   = illegal_q;
    assign bus.hilo_busy = hilo_busy_q;

endmodule
